// File: rtl/text_run_scheduler.sv
// Steps a run of ASCII characters from a synchronous text buffer through one
// glyph renderer, advancing the cursor and wrapping lines at a right-hand limit.
module text_run_scheduler #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int CHAR_W = 7,
  parameter int SIZE_W = 4,
  parameter int IDX_W  = 6,
  parameter int FONT_W = 5,
  parameter int FONT_H = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [X_W-1:0]    base_x,
  input  logic [Y_W-1:0]    base_y,
  input  logic [X_W-1:0]    wrap_x,
  input  logic [SIZE_W-1:0] size,
  input  logic [IDX_W-1:0]  char_count,
  output logic [IDX_W-1:0]  buf_idx,
  input  logic [CHAR_W-1:0] buf_data,
  output logic [CHAR_W-1:0] r_char,
  output logic [X_W-1:0]    r_origin_x,
  output logic [Y_W-1:0]    r_origin_y,
  output logic [SIZE_W-1:0] r_size,
  output logic              r_enable,
  input  logic              r_finished,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [CHAR_W-1:0] CH_NL = CHAR_W'(10);
  localparam logic [CHAR_W-1:0] CH_SP = CHAR_W'(32);
  localparam logic [X_W-1:0]    PITCH_K = X_W'(FONT_W + 1);
  localparam logic [X_W-1:0]    GLYPH_K = X_W'(FONT_W);
  localparam logic [Y_W-1:0]    LINE_K  = Y_W'(FONT_H + 1);

  logic [2:0]       r_state;
  logic [X_W-1:0]   r_base_x;
  logic [X_W-1:0]   r_wrap_x;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_idx;
  logic [X_W-1:0]   r_cur_x;
  logic [Y_W-1:0]   r_cur_y;

  logic [X_W-1:0]   w_pitch_x;
  logic [Y_W-1:0]   w_line_h;
  logic [X_W-1:0]   w_right;
  logic [Y_W-1:0]   w_next_y;
  logic             w_wrap;
  logic [IDX_W:0]   w_idx_inc;

  // Geometry is derived from the captured size so the run is immune to input changes.
  assign w_pitch_x = X_W'(r_size) * PITCH_K;
  assign w_line_h  = Y_W'(r_size) * LINE_K;
  assign w_right   = r_cur_x + X_W'(r_size) * GLYPH_K;
  assign w_next_y  = r_cur_y + w_line_h;
  // A glyph already at the margin never wraps, so oversized glyphs cannot loop.
  assign w_wrap    = (w_right > r_wrap_x) && (r_cur_x != r_base_x);
  assign w_idx_inc = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};

  assign buf_idx = r_idx;
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_base_x   <= '0;
      r_wrap_x   <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_char     <= '0;
      r_origin_x <= '0;
      r_origin_y <= '0;
      r_size     <= '0;
      r_enable   <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      r_state  <= S_IDLE;
      r_enable <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base_x <= base_x;
            r_wrap_x <= wrap_x;
            r_size   <= size;
            r_count  <= char_count;
            r_cur_x  <= base_x;
            r_cur_y  <= base_y;
            r_idx    <= '0;
            r_state  <= (char_count == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          if (buf_data == CH_NL) begin
            r_cur_x <= r_base_x;
            r_cur_y <= w_next_y;
            r_state <= S_NEXT;
          end else if (buf_data == CH_SP) begin
            r_cur_x <= r_cur_x + w_pitch_x;
            r_state <= S_NEXT;
          end else begin
            if (w_wrap) begin
              r_cur_x    <= r_base_x;
              r_cur_y    <= w_next_y;
              r_origin_x <= r_base_x;
              r_origin_y <= w_next_y;
            end else begin
              r_origin_x <= r_cur_x;
              r_origin_y <= r_cur_y;
            end
            r_char   <= buf_data;
            r_enable <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_finished) begin
            r_enable <= 1'b0;
            r_cur_x  <= r_cur_x + w_pitch_x;
            r_state  <= S_GAP;
          end
        end
        S_GAP: r_state <= S_NEXT;
        S_NEXT: begin
          r_idx   <= w_idx_inc[IDX_W-1:0];
          // Compare one bit wider so a full-length run terminates before idx wraps.
          r_state <= (w_idx_inc == {1'b0, r_count}) ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_run_scheduler.sv
// Bench for text_run_scheduler: synchronous buffer, stub renderer and a
// string-level layout model that predicts every glyph origin and gap.
module tb_text_run_scheduler;
  localparam int X_W = 10, Y_W = 9, CHAR_W = 7, SIZE_W = 4, IDX_W = 6;
  localparam int LAT = 5;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [X_W-1:0]    base_x = '0;
  logic [Y_W-1:0]    base_y = '0;
  logic [X_W-1:0]    wrap_x = '0;
  logic [SIZE_W-1:0] size = '0;
  logic [IDX_W-1:0]  char_count = '0;
  logic [IDX_W-1:0]  buf_idx;
  logic [CHAR_W-1:0] buf_data = '0;
  logic [CHAR_W-1:0] r_char;
  logic [X_W-1:0]    r_origin_x;
  logic [Y_W-1:0]    r_origin_y;
  logic [SIZE_W-1:0] r_size;
  logic              r_enable;
  logic              r_finished;
  logic              busy;
  logic              done;

  text_run_scheduler dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .base_x(base_x), .base_y(base_y), .wrap_x(wrap_x), .size(size),
    .char_count(char_count), .buf_idx(buf_idx), .buf_data(buf_data),
    .r_char(r_char), .r_origin_x(r_origin_x), .r_origin_y(r_origin_y),
    .r_size(r_size), .r_enable(r_enable), .r_finished(r_finished),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [CHAR_W-1:0] mem [0:63];
  always @(posedge clock) buf_data <= mem[buf_idx];

  // Stub renderer finishes on its LAT-th enabled cycle; spurious finishes while idle.
  int rcnt;
  bit noise;
  always @(posedge clock or negedge resetn)
    if (!resetn) rcnt <= 0;
    else if (!r_enable) rcnt <= 0;
    else rcnt <= rcnt + 1;
  always @(negedge clock) noise = ($urandom_range(0, 2) == 0);
  assign r_finished = (r_enable && rcnt == LAT - 1) || (!r_enable && noise);

  typedef struct packed {
    logic [CHAR_W-1:0] c;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
  } glyph_t;

  glyph_t got_q[$], exp_q[$];
  int     got_gap[$], exp_gap[$];
  glyph_t cur_g;
  bit     prev_en, prev_done, have_prev;
  int     low_cnt, done_cnt, wide_cnt, unstable;

  always @(negedge clock) begin
    if (r_enable) begin
      if (!prev_en) begin
        cur_g = '{r_char, r_origin_x, r_origin_y};
        got_q.push_back(cur_g);
        if (have_prev) got_gap.push_back(low_cnt);
        have_prev = 1'b1;
      end else if (cur_g != glyph_t'({r_char, r_origin_x, r_origin_y})) begin
        unstable++;
      end
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (prev_done) wide_cnt++;
    end
    prev_en = r_enable;
    prev_done = done;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); got_gap.delete();
    have_prev = 1'b0; done_cnt = 0; wide_cnt = 0; unstable = 0; low_cnt = 0;
  endtask

  task automatic load(string s);
    for (int i = 0; i < s.len(); i++) mem[i] = CHAR_W'(s[i]);
  endtask

  // Layout from the text rules: draw chars get an origin, newline/space only move the cursor.
  // Enable-low time between two drawn glyphs is the 4-cycle overhead plus 3 per skipped char.
  task automatic model(int n, int bx, int by, int wx, int sz);
    int cx, cy, k;
    bit first;
    glyph_t g;
    exp_q.delete(); exp_gap.delete();
    cx = bx; cy = by; k = 0; first = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (mem[i] == 7'd10) begin
        cx = bx; cy = (cy + sz * 8) % 512; k++;
      end else if (mem[i] == 7'd32) begin
        cx = (cx + sz * 6) % 1024; k++;
      end else begin
        if (((cx + sz * 5) % 1024) > wx && cx != bx) begin
          cx = bx; cy = (cy + sz * 8) % 512;
        end
        g = '{mem[i], X_W'(cx), Y_W'(cy)};
        exp_q.push_back(g);
        if (!first) exp_gap.push_back(4 + 3 * k);
        first = 1'b0; k = 0;
        cx = (cx + sz * 6) % 1024;
      end
    end
  endtask

  task automatic run(string tag, int n, int bx, int by, int wx, int sz,
                     bit chk_lat, bit busy_start);
    int budget;
    model(n, bx, by, wx, sz);
    clear_mon();
    base_x = X_W'(bx); base_y = Y_W'(by); wrap_x = X_W'(wx);
    size = SIZE_W'(sz); char_count = IDX_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    if (chk_lat) begin
      check({tag, "_lat1"}, {31'd0, r_enable}, 0);
      check({tag, "_idx0"}, 32'(buf_idx), 0);
      step();
      check({tag, "_lat2"}, {31'd0, r_enable}, 0);
      step();
      check({tag, "_lat3"}, {31'd0, r_enable}, 1);
    end
    budget = n * (LAT + 8) + 20;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (busy_start && i == 4) begin
        base_x = X_W'(bx + 77); base_y = Y_W'(by + 33); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    step(); step();
    check({tag, "_done"}, 32'(done_cnt), 1);
    check({tag, "_done_w"}, 32'(wide_cnt), 0);
    check({tag, "_stable"}, 32'(unstable), 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_nglyph"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_g%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    for (int i = 0; i < got_gap.size() && i < exp_gap.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), 32'(got_gap[i]), 32'(exp_gap[i]));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 7'd65;
    step(); step();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_en", {31'd0, r_enable}, 0);
    check("rst_idx", 32'(buf_idx), 0);
    check("rst_ox", 32'(r_origin_x), 0);
    resetn = 1'b1;
    step();

    load("AB");
    run("t1", 2, 10, 20, 300, 2, 1'b1, 1'b0);
    check("t1_x1", 32'(got_q.size() > 1 ? got_q[1].x : 10'h3ff), 22);

    load("A B");
    run("t2", 3, 0, 0, 300, 1, 1'b1, 1'b0);
    check("t2_x1", 32'(got_q.size() > 1 ? got_q[1].x : 10'h3ff), 12);

    load("AAA");
    run("t3", 3, 0, 0, 14, 1, 1'b1, 1'b0);
    check("t3_y2", 32'(got_q.size() > 2 ? got_q[2].y : 9'h1ff), 8);

    load("A\nB");
    run("t4", 3, 5, 5, 300, 3, 1'b1, 1'b0);
    check("t4_y1", 32'(got_q.size() > 1 ? got_q[1].y : 9'h1ff), 29);

    load("AA");
    run("wide", 2, 100, 10, 50, 4, 1'b0, 1'b0);

    clear_mon();
    char_count = '0; start = 1'b1;
    step();
    start = 1'b0;
    check("t5_done1", {31'd0, done}, 0);
    step();
    check("t5_done2", {31'd0, done}, 1);
    step();
    check("t5_ndone", 32'(done_cnt), 1);
    check("t5_noen", 32'(got_q.size()), 0);

    load("AB");
    clear_mon();
    base_x = 10; base_y = 20; wrap_x = 300; size = 2; char_count = 2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && got_q.size() < 2; i++) step();
    check("t6_reach", 32'(got_q.size()), 2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_idle", {31'd0, busy}, 0);
    check("t6_en", {31'd0, r_enable}, 0);
    repeat (6) step();
    check("t6_nodone", 32'(done_cnt), 0);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_prio", {31'd0, busy}, 0);

    run("t6_busy", 2, 10, 20, 300, 2, 1'b0, 1'b1);

    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !r_enable; i++) step();
    check("arst_run", {31'd0, r_enable}, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_en", {31'd0, r_enable}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    step();
    resetn = 1'b1;
    step(); step();
    check("arst_nodone", 32'(done_cnt), 0);

    for (int i = 0; i < 63; i++) begin
      int r;
      r = $urandom_range(0, 9);
      mem[i] = (r == 0) ? 7'd10 : (r == 1) ? 7'd32 : CHAR_W'(65 + $urandom_range(0, 25));
    end
    run("max", 63, 3, 7, 200, 1, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n, bx;
      n = $urandom_range(1, 20);
      bx = $urandom_range(0, 100);
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 7);
        mem[i] = (r == 0) ? 7'd10 : (r == 1) ? 7'd32 : CHAR_W'(65 + $urandom_range(0, 25));
      end
      run($sformatf("rnd%0d", t), n, bx, $urandom_range(0, 100),
          bx + $urandom_range(0, 200), $urandom_range(1, 4), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
